// File: rtl/general_arith_pkg.sv
// rtl/general_arith_pkg.sv - shared FSM state type and width helper for the arithmetic units
package general_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } arith_state_t;

   // Counter width able to hold the value `steps` itself (the final step count).
   function automatic int cnt_width(input int steps);
      return (steps < 1) ? 1 : $clog2(steps + 1);
   endfunction

endpackage

// File: rtl/general_multiplier_step.sv
// rtl/general_multiplier_step.sv - one shift-and-add iteration of the multiplier work register
module general_multiplier_step #(
   parameter int WIDTH_A = 4,
   parameter int WIDTH_B = 4
) (
   input  logic [WIDTH_A+WIDTH_B:0] pr_i,
   input  logic [WIDTH_B-1:0]       b_i,
   output logic [WIDTH_A+WIDTH_B:0] pr_o
);

   logic [WIDTH_B:0] upper;
   logic [WIDTH_B:0] sum;

   always_comb begin
      upper = pr_i[WIDTH_A+WIDTH_B:WIDTH_A];
      // Upper field is one bit wider than b so the carry of the add survives the shift.
      sum   = pr_i[0] ? (upper + {1'b0, b_i}) : upper;
      pr_o  = {sum, pr_i[WIDTH_A-1:0]} >> 1;
   end

endmodule

// File: rtl/general_multiplier.sv
// rtl/general_multiplier.sv - sequential unsigned shift-and-add multiplier with start/busy/done handshake
module general_multiplier
   import general_arith_pkg::*;
#(
   parameter int WIDTH_A = 4,
   parameter int WIDTH_B = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH_A-1:0]         A,
   input  logic [WIDTH_B-1:0]         B,
   output logic [WIDTH_A+WIDTH_B-1:0] P,
   output logic                       busy,
   output logic                       done
);

   localparam int PW = WIDTH_A + WIDTH_B + 1;
   localparam int CW = cnt_width(WIDTH_A);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH_A - 1);

   arith_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pr_q, pr_d, pr_step;
   logic [WIDTH_B-1:0] b_q, b_d;
   logic [PW-2:0] p_q, p_d;
   logic          done_q, done_d;

   general_multiplier_step #(
      .WIDTH_A (WIDTH_A),
      .WIDTH_B (WIDTH_B)
   ) u_step (
      .pr_i (pr_q),
      .b_i  (b_q),
      .pr_o (pr_step)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pr_d    = pr_q;
      b_d     = b_q;
      p_d     = p_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               b_d     = B;
               pr_d    = {{(WIDTH_B + 1){1'b0}}, A};
               cnt_d   = '0;
            end
         end
         RUN: begin
            pr_d  = pr_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Product is published on the way out so P never moves during RUN.
            state_d = IDLE;
            p_d     = pr_q[PW-2:0];
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pr_q    <= '0;
         b_q     <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pr_q    <= pr_d;
         b_q     <= b_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign P    = p_q;
   assign busy = (state_q == RUN);
   assign done = done_q;

endmodule
